// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: FWFT trace FIFO of register writes tagged with a
// sequence number, plus a shadow copy of the architectural registers x1..x31.
module wb_trace_buffer #(
   parameter int DATA_SIZE = 32,
   parameter int DEPTH     = 16,
   parameter int SEQ_SIZE  = 16
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   CLEAR,
   input  logic                   wb_valid,
   input  logic [4:0]             wb_rd,
   input  logic [DATA_SIZE-1:0]   wb_data,
   output logic                   trace_valid,
   input  logic                   trace_ready,
   output logic [4:0]             trace_rd,
   output logic [DATA_SIZE-1:0]   trace_data,
   output logic [SEQ_SIZE-1:0]    trace_seq,
   input  logic [4:0]             shadow_addr,
   output logic [DATA_SIZE-1:0]   shadow_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow,
   output logic [15:0]            dropped_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [4:0]           rd_mem   [DEPTH];
   logic [DATA_SIZE-1:0] data_mem [DEPTH];
   logic [SEQ_SIZE-1:0]  seq_mem  [DEPTH];
   logic [DATA_SIZE-1:0] shadow   [32];

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       cnt;
   logic [SEQ_SIZE-1:0] seq;
   logic                ovf;
   logic [15:0]         drops;

   logic qual;
   logic pop;
   logic push;
   logic drop;

   assign qual = wb_valid & (wb_rd != 5'd0);
   assign full = (cnt == FULL_CNT);
   assign trace_valid = (cnt != '0);
   assign pop  = trace_valid & trace_ready & ~CLEAR;
   assign push = qual & ~CLEAR & (~full | pop);
   assign drop = qual & ~CLEAR & full & ~pop;

   assign count       = cnt;
   assign overflow    = ovf;
   assign dropped_cnt = drops;

   assign trace_rd   = rd_mem[rd_ptr];
   assign trace_data = data_mem[rd_ptr];
   assign trace_seq  = seq_mem[rd_ptr];

   assign shadow_data = (shadow_addr == 5'd0) ? '0 : shadow[shadow_addr];

   // Entry storage; contents are meaningless until pushed, so no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         rd_mem[wr_ptr]   <= wb_rd;
         data_mem[wr_ptr] <= wb_data;
         seq_mem[wr_ptr]  <= seq;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count alone.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (CLEAR) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            cnt <= cnt + CW'(1);
         else if (pop && !push)
            cnt <= cnt - CW'(1);
      end
   end

   // Sequence tag advances on every qualifying event, stored or dropped.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         seq <= '0;
      else if (CLEAR)
         seq <= '0;
      else if (qual)
         seq <= seq + SEQ_SIZE'(1);
   end

   // Drop accounting: sticky overflow and a saturating drop counter.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ovf   <= 1'b0;
         drops <= '0;
      end else if (CLEAR) begin
         ovf   <= 1'b0;
         drops <= '0;
      end else if (drop) begin
         ovf <= 1'b1;
         if (drops != 16'hFFFF) drops <= drops + 16'd1;
      end
   end

   // Shadow registers mirror the core's bank, so CLEAR leaves them intact.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < 32; i++) shadow[i] <= '0;
      end else if (qual) begin
         shadow[wb_rd] <= wb_data;
      end
   end

endmodule
